eth_txarb_rr: RTL and testbench
===============================

# eth_txarb_rr

Frame-level round-robin arbiter that merges NUM_CH first-word-fall-through (FWFT) TX FIFOs into one downstream Ethernet TX FIFO. It sits between per-source TX queues and the MAC-side TX FIFO, and is the multi-channel successor to the two-input fixed-priority TX arbiter. Frames are never interleaved: once a channel is granted, every beat up to and including its tlast beat is forwarded before re-arbitration. Grant rotates round-robin, so no source can starve another.

## Interface
- NUM_CH, 4: number of input channels; must be at least 2.
- W, 74: word width. The word format is opaque except for the tlast bit.
- TLAST_BIT, 1: bit index of tlast within a word.
- CNT_W, 32: width of the per-channel frame counters.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset, synchronous and active-low.
- fifo_dout  in  [NUM_CH][W]  FWFT head word of each input FIFO.
- fifo_empty  in  [NUM_CH]  input FIFO empty flags.
- fifo_rd_en  out  [NUM_CH]  pop strobes, one per channel. Combinational from registered state.
- din  out  W  word written to the downstream FIFO (registered).
- full  in  1  downstream FIFO programmable-full. It must assert with at least 1 free entry of headroom.
- wr_en  out  1  downstream write strobe (registered).
- busy  out  1  high while in XFER.
- cur_ch  out  $clog2(NUM_CH)  currently granted channel; valid while busy.
- frame_cnt  out  [NUM_CH][CNT_W]  completed frames forwarded per channel. Each counter wraps modulo 2^CNT_W.

## Operation
States:
- IDLE: fifo_rd_en is all zero.
  - If full is low and any channel is non-empty, grant the first non-empty channel at or after rr_ptr, searching upward modulo NUM_CH.
  - Register the grant into cur_ch and go to XFER.
  - If full is high, or no channel is non-empty, stay in IDLE.
- XFER: fifo_rd_en[cur_ch] = !fifo_empty[cur_ch] && !full. All other rd_en bits are 0.
  - On each pop, the next cycle has din = the popped word and wr_en = 1. When no pop occurs, wr_en = 0 and din holds its previous value.
  - When the popped word has tlast set:
    - next state is IDLE;
    - rr_ptr becomes (cur_ch+1) mod NUM_CH;
    - frame_cnt[cur_ch] increments.
  - Empty or full in mid-frame stalls the transfer. The grant is held and no timeout applies.
- Any other state encoding returns to IDLE.

Single-beat frames (tlast on the first word) are legal and return to IDLE after one pop.

Reset (rst_n = 0 at a clk edge) applies in any state:
- state goes to IDLE; rr_ptr, cur_ch, din, wr_en, busy and all frame_cnt become 0.
- fifo_rd_en is 0 from the cycle after the reset edge.
- A reset mid-frame leaves a truncated frame downstream. Recovering from that is the system's responsibility.

## Timing
- Arbitration latency: a channel that is non-empty in IDLE (with full low) at edge k has its first pop asserted in cycle k+1. The matching wr_en/din appear at k+2.
- Sustained throughput in XFER is 1 word per clock while the source is non-empty and full is low.
- Inter-frame overhead is exactly 1 IDLE cycle.
- wr_en trails fifo_rd_en by exactly 1 cycle. At most 1 write lands after full rises, which is why full needs the 1-entry headroom.
- The search is a pure function of fifo_empty and rr_ptr: a priority search rotated by rr_ptr. It is computed combinationally in IDLE and registered on the transition.
- Simultaneous requests are resolved by rr_ptr order only. A channel that becomes non-empty while another channel is in XFER waits for that channel's tlast.

## Structure
- Shared package eth_pkg holds:
  - the W = 74 and TLAST_BIT = 1 constants;
  - the state enum {IDLE, XFER}.
- Sub-module eth_rr_pick(NUM_CH) is the rotating priority search:
  - inputs: req[NUM_CH], ptr.
  - outputs: gnt_idx, gnt_vld.
  - It is purely combinational and reusable by the RX distributor.

## Test plan
1. Single channel, NUM_CH = 4: ch2 holds a 3-beat frame. Required: rd_en[2] in cycles 1–3, wr_en in cycles 2–4 with words in order, frame_cnt[2] = 1, rr_ptr = 3.
2. All 4 channels each hold two 1-beat frames. Required: output channel order 0,1,2,3,0,1,2,3, with a 1-cycle gap between frames.
3. ch1 goes empty mid-frame for 5 cycles while ch0 holds a frame. Required: cur_ch stays 1, no ch0 word is forwarded before ch1's tlast, and the output is contiguous per frame.
4. full raised during beat 4 of an 8-beat frame, held for 3 cycles. Required: at most 1 further wr_en after the rise, no word lost or duplicated, 8 words total.
5. rst_n low mid-frame on ch3. Required: the next cycle has wr_en = 0, din = 0 and all rd_en = 0, and all frame_cnt = 0. After release, arbitration restarts from ch0.
6. frame_cnt with CNT_W = 4: forward 17 frames on ch0. Required: frame_cnt[0] = 1, confirming the wrap.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet TX/RX datapath blocks.
package eth_pkg;

    localparam int W         = 74;
    localparam int TLAST_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01
    } arb_state_e;

endpackage

// File: rtl/eth_rr_pick.sv
// Rotating priority search: first asserted req at or above ptr, wrapping modulo NUM_CH.
// Purely combinational so the TX arbiter and RX distributor can share it.
module eth_rr_pick #(
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    logic [31:0] c;

    // Walk offsets from farthest to nearest so the nearest request is written last and wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        c       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = (32'(ptr) + 32'(i)) % 32'(NUM_CH);
            if (req[c[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = c[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/eth_txarb_rr.sv
// Frame-level round-robin merge of NUM_CH FWFT TX FIFOs into one downstream TX FIFO.
// A granted channel keeps the output until its tlast beat has been forwarded.
module eth_txarb_rr #(
    parameter  int NUM_CH    = 4,
    parameter  int W         = eth_pkg::W,
    parameter  int TLAST_BIT = eth_pkg::TLAST_BIT,
    parameter  int CNT_W     = 32,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_CH-1:0][W-1:0]        fifo_dout,
    input  logic [NUM_CH-1:0]               fifo_empty,
    output logic [NUM_CH-1:0]               fifo_rd_en,
    output logic [W-1:0]                    din,
    input  logic                            full,
    output logic                            wr_en,
    output logic                            busy,
    output logic [CH_W-1:0]                 cur_ch,
    output logic [NUM_CH-1:0][CNT_W-1:0]    frame_cnt
);

    import eth_pkg::*;

    arb_state_e                   state_q,  state_d;
    logic [CH_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]              cur_ch_q, cur_ch_d;
    logic [W-1:0]                 din_q,    din_d;
    logic                         wr_en_q,  wr_en_d;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q,    cnt_d;

    logic [NUM_CH-1:0]            req;
    logic [CH_W-1:0]              pick_idx;
    logic                         pick_vld;
    logic [W-1:0]                 head;
    logic                         pop;

    assign req = ~fifo_empty;

    eth_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .gnt_vld (pick_vld)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_ch_d   = cur_ch_q;
        din_d      = din_q;
        wr_en_d    = 1'b0;
        cnt_d      = cnt_q;
        fifo_rd_en = '0;
        head       = fifo_dout[cur_ch_q];
        pop        = 1'b0;

        case (state_q)
            IDLE: begin
                if (!full && pick_vld) begin
                    state_d  = XFER;
                    cur_ch_d = pick_idx;
                end
            end
            XFER: begin
                // full carries one entry of headroom, so the write trailing this pop always fits.
                pop                  = !fifo_empty[cur_ch_q] && !full;
                fifo_rd_en[cur_ch_q] = pop;
                if (pop) begin
                    din_d   = head;
                    wr_en_d = 1'b1;
                    if (head[TLAST_BIT]) begin
                        state_d         = IDLE;
                        rr_ptr_d        = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);
                        cnt_d[cur_ch_q] = cnt_q[cur_ch_q] + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cur_ch_q <= '0;
            din_q    <= '0;
            wr_en_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_ch_q <= cur_ch_d;
            din_q    <= din_d;
            wr_en_q  <= wr_en_d;
            cnt_q    <= cnt_d;
        end
    end

    assign din       = din_q;
    assign wr_en     = wr_en_q;
    assign busy      = (state_q == XFER);
    assign cur_ch    = cur_ch_q;
    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_eth_txarb_rr.sv
// Bench for eth_txarb_rr: array-backed FWFT FIFO models feed the DUT and a
// frame-level reference model predicts the outputs every cycle.
module tb_eth_txarb_rr;

    localparam int N     = 4;
    localparam int WW    = eth_pkg::W;
    localparam int TL    = eth_pkg::TLAST_BIT;
    localparam int CW    = 4;
    localparam int CHW   = 2;
    localparam int DEPTH = 1024;
    localparam int VW    = N + 1 + WW + 1 + CHW + N * CW;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    logic [N-1:0][WW-1:0]    fifo_dout;
    logic [N-1:0]            fifo_empty;
    logic [N-1:0]            fifo_rd_en;
    logic [WW-1:0]           din;
    logic                    full  = 1'b0;
    logic                    wr_en;
    logic                    busy;
    logic [CHW-1:0]          cur_ch;
    logic [N-1:0][CW-1:0]    frame_cnt;

    always #5 clk = ~clk;

    eth_txarb_rr #(.NUM_CH(N), .W(WW), .TLAST_BIT(TL), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .din        (din),
        .full       (full),
        .wr_en      (wr_en),
        .busy       (busy),
        .cur_ch     (cur_ch),
        .frame_cnt  (frame_cnt)
    );

    logic [WW-1:0] mem [N][DEPTH];
    int            hd [N];
    int            tl [N];
    int            nfr[N];
    logic [N-1:0]  hold = '0;
    int            chk = 0;
    int            err = 0;

    int                   m_own = -1;
    int                   m_ptr = 0;
    logic                 m_wr  = 1'b0;
    logic [WW-1:0]        m_din = '0;
    logic [N-1:0][CW-1:0] m_cnt = '0;

    logic [N-1:0]   s_rd;
    logic           s_wr, s_busy;
    logic [WW-1:0]  s_din;
    logic [CHW-1:0] s_cur;
    logic [VW-1:0]  s_vec, e_vec;

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            fifo_empty[c] = (hd[c] == tl[c]) || hold[c];
            fifo_dout[c]  = (hd[c] == tl[c]) ? '0 : mem[c][hd[c]];
        end
    endtask

    task automatic push_frame(input int c, input int len);
        logic [95:0]   r;
        logic [WW-1:0] w;
        for (int i = 0; i < len; i++) begin
            r = {$urandom, $urandom, $urandom};
            w = r[WW-1:0];
            w[WW-1 -: CHW] = CHW'(c);
            w[TL] = (i == len - 1);
            mem[c][tl[c]] = w;
            tl[c]++;
        end
        nfr[c]++;
    endtask

    // One clock: sample at negedge, predict from frame rules, then apply pops after the edge.
    task automatic cycle();
        logic [N-1:0]   e_rd, popped;
        logic [CHW-1:0] e_cur;
        logic [WW-1:0]  w;
        @(negedge clk);
        e_rd = '0;
        if (m_own >= 0 && !fifo_empty[m_own] && !full) e_rd[m_own] = 1'b1;
        e_cur  = (m_own >= 0) ? CHW'(m_own) : '0;
        s_rd   = fifo_rd_en;
        s_wr   = wr_en;
        s_din  = din;
        s_busy = busy;
        s_cur  = busy ? cur_ch : '0;
        s_vec  = {s_rd, s_wr, s_din, s_busy, s_cur, frame_cnt};
        e_vec  = {e_rd, m_wr, m_din, (m_own >= 0), e_cur, m_cnt};
        popped = fifo_rd_en & ~fifo_empty;
        if (!rst_n) begin
            m_own = -1; m_ptr = 0; m_wr = 1'b0; m_din = '0; m_cnt = '0;
        end else if (m_own >= 0) begin
            m_wr = e_rd[m_own];
            if (m_wr) begin
                w     = mem[m_own][hd[m_own]];
                m_din = w;
                if (w[TL]) begin
                    m_cnt[m_own] = m_cnt[m_own] + CW'(1);
                    m_ptr = (m_own + 1) % N;
                    m_own = -1;
                end
            end
        end else begin
            m_wr = 1'b0;
            if (!full)
                for (int i = 0; i < N && m_own < 0; i++)
                    if (!fifo_empty[(m_ptr + i) % N]) m_own = (m_ptr + i) % N;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) if (popped[c] === 1'b1) hd[c]++;
        drive();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        full  = 1'b0;
        hold  = '0;
        for (int c = 0; c < N; c++) begin hd[c] = 0; tl[c] = 0; nfr[c] = 0; end
        drive();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        cycle();
        chk++;
        if (s_vec !== '0) begin err++; $display("FAIL reset_state got %h exp 0", s_vec); end
        chk++;
        if (s_vec !== e_vec) begin err++; $display("FAIL reset_model got %h exp %h", s_vec, e_vec); end
    endtask

    task automatic test_single();
        int first_rd = -1, first_wr = -1, nrd = 0, nwr = 0, first_cur = -1;
        int tags[$];
        apply_reset();
        push_frame(2, 3);
        drive();
        for (int k = 0; k < 12; k++) begin
            cycle();
            chk++;
            if (s_vec !== e_vec) begin err++; $display("FAIL single cyc%0d got %h exp %h", k, s_vec, e_vec); end
            if (s_rd[2]) begin nrd++; if (first_rd < 0) first_rd = k; end
            if (s_wr) begin
                if (first_wr < 0) first_wr = k;
                chk++;
                if (s_din !== mem[2][nwr]) begin err++; $display("FAIL single_word%0d got %h exp %h", nwr, s_din, mem[2][nwr]); end
                nwr++;
            end
        end
        chk++; if (first_rd != 1) begin err++; $display("FAIL single_first_rd got %0d exp 1", first_rd); end
        chk++; if (first_wr != 2) begin err++; $display("FAIL single_first_wr got %0d exp 2", first_wr); end
        chk++; if (nrd != 3 || nwr != 3) begin err++; $display("FAIL single_beats got rd%0d wr%0d exp 3", nrd, nwr); end
        chk++; if (frame_cnt[2] !== CW'(1)) begin err++; $display("FAIL single_cnt got %0d exp 1", frame_cnt[2]); end
        // Pointer now sits past ch2, so ch3 must beat ch0.
        push_frame(0, 1);
        push_frame(3, 1);
        drive();
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk++;
            if (s_vec !== e_vec) begin err++; $display("FAIL single_ptr cyc%0d got %h exp %h", k, s_vec, e_vec); end
            if (s_busy && first_cur < 0) first_cur = int'(s_cur);
            if (s_wr) tags.push_back(int'(s_din[WW-1 -: CHW]));
        end
        chk++; if (first_cur != 3) begin err++; $display("FAIL single_rrptr got %0d exp 3", first_cur); end
        chk++;
        if (tags.size() != 2 || tags[0] != 3 || tags[1] != 0) begin
            err++; $display("FAIL single_order got n%0d exp 3,0", tags.size());
        end
    endtask

    task automatic test_rr();
        int tags[$];
        int wcyc[$];
        apply_reset();
        for (int r = 0; r < 2; r++) for (int c = 0; c < N; c++) push_frame(c, 1);
        drive();
        for (int k = 0; k < 30; k++) begin
            cycle();
            chk++;
            if (s_vec !== e_vec) begin err++; $display("FAIL rr cyc%0d got %h exp %h", k, s_vec, e_vec); end
            if (s_wr) begin tags.push_back(int'(s_din[WW-1 -: CHW])); wcyc.push_back(k); end
        end
        chk++;
        if (tags.size() != 8) begin err++; $display("FAIL rr_count got %0d exp 8", tags.size()); end
        for (int i = 0; i < tags.size() && i < 8; i++) begin
            chk++;
            if (tags[i] != i % N) begin err++; $display("FAIL rr_order%0d got %0d exp %0d", i, tags[i], i % N); end
            if (i > 0) begin
                chk++;
                if (wcyc[i] - wcyc[i-1] != 2) begin err++; $display("FAIL rr_gap%0d got %0d exp 2", i, wcyc[i] - wcyc[i-1]); end
            end
        end
    endtask

    task automatic test_stall();
        int tags[$];
        int exp_tags[7] = '{1, 1, 1, 1, 0, 0, 0};
        apply_reset();
        push_frame(1, 4);
        drive();
        cycle();
        chk++;
        if (s_vec !== e_vec) begin err++; $display("FAIL stall_grant got %h exp %h", s_vec, e_vec); end
        push_frame(0, 3);
        drive();
        for (int k = 0; k < 30; k++) begin
            cycle();
            chk++;
            if (s_vec !== e_vec) begin err++; $display("FAIL stall cyc%0d got %h exp %h", k, s_vec, e_vec); end
            if (k >= 2 && k <= 6) begin
                chk++;
                if (!(s_busy === 1'b1 && s_cur === CHW'(1) && s_rd === '0)) begin
                    err++; $display("FAIL stall_hold cyc%0d got busy%b ch%0d rd%b exp busy1 ch1 rd0", k, s_busy, s_cur, s_rd);
                end
            end
            if (s_wr) tags.push_back(int'(s_din[WW-1 -: CHW]));
            if (k == 1) hold[1] = 1'b1;
            if (k == 6) hold[1] = 1'b0;
            drive();
        end
        chk++;
        if (tags.size() != 7) begin err++; $display("FAIL stall_count got %0d exp 7", tags.size()); end
        for (int i = 0; i < tags.size() && i < 7; i++) begin
            chk++;
            if (tags[i] != exp_tags[i]) begin err++; $display("FAIL stall_order%0d got %0d exp %0d", i, tags[i], exp_tags[i]); end
        end
    endtask

    task automatic test_full();
        int pops = 0, nwr = 0, fk = -100, after = 0;
        apply_reset();
        push_frame(2, 8);
        drive();
        for (int k = 0; k < 40; k++) begin
            cycle();
            chk++;
            if (s_vec !== e_vec) begin err++; $display("FAIL full cyc%0d got %h exp %h", k, s_vec, e_vec); end
            if (s_wr) begin
                if (k > fk && k <= fk + 3) after++;
                chk++;
                if (nwr >= 8 || s_din !== mem[2][nwr]) begin err++; $display("FAIL full_word%0d got %h exp %h", nwr, s_din, mem[2][nwr % 8]); end
                nwr++;
            end
            if (s_rd[2]) pops++;
            if (pops == 4 && fk < 0) begin full = 1'b1; fk = k; end
            else if (fk >= 0 && k == fk + 3) full = 1'b0;
        end
        chk++; if (after > 1) begin err++; $display("FAIL full_after got %0d exp <=1", after); end
        chk++; if (nwr != 8) begin err++; $display("FAIL full_total got %0d exp 8", nwr); end
    endtask

    task automatic test_reset_mid();
        int pops = 0;
        apply_reset();
        push_frame(1, 1);
        push_frame(3, 6);
        drive();
        for (int k = 0; k < 30 && pops < 2; k++) begin
            cycle();
            chk++;
            if (s_vec !== e_vec) begin err++; $display("FAIL rstmid cyc%0d got %h exp %h", k, s_vec, e_vec); end
            if (s_rd[3]) pops++;
        end
        chk++; if (pops != 2) begin err++; $display("FAIL rstmid_reach got %0d exp 2", pops); end
        rst_n = 1'b0;
        cycle();
        chk++;
        if (s_vec !== e_vec) begin err++; $display("FAIL rstmid_edge got %h exp %h", s_vec, e_vec); end
        rst_n = 1'b1;
        push_frame(0, 1);
        drive();
        cycle();
        chk++;
        if ({s_rd, s_wr, s_din, frame_cnt} !== '0) begin
            err++; $display("FAIL rstmid_clear got rd%b wr%b din%h cnt%h exp 0", s_rd, s_wr, s_din, frame_cnt);
        end
        cycle();
        chk++;
        if (!(s_busy === 1'b1 && s_cur === CHW'(0))) begin err++; $display("FAIL rstmid_restart got busy%b ch%0d exp busy1 ch0", s_busy, s_cur); end
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk++;
            if (s_vec !== e_vec) begin err++; $display("FAIL rstmid_drain cyc%0d got %h exp %h", k, s_vec, e_vec); end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int f = 0; f < 17; f++) push_frame(0, 1);
        drive();
        for (int k = 0; k < 45; k++) begin
            cycle();
            chk++;
            if (s_vec !== e_vec) begin err++; $display("FAIL wrap cyc%0d got %h exp %h", k, s_vec, e_vec); end
        end
        chk++;
        if (frame_cnt[0] !== CW'(17 % (1 << CW))) begin err++; $display("FAIL wrap_cnt got %0d exp %0d", frame_cnt[0], 17 % (1 << CW)); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int k = 0; k < 700; k++) begin
            if (k < 500) begin
                if ($urandom_range(7) == 0) push_frame(int'($urandom_range(N - 1)), int'($urandom_range(5, 1)));
                full = ($urandom_range(4) == 0);
                for (int c = 0; c < N; c++) hold[c] = ($urandom_range(9) == 0);
            end else begin
                full = 1'b0;
                hold = '0;
            end
            drive();
            cycle();
            chk++;
            if (s_vec !== e_vec) begin err++; $display("FAIL random cyc%0d got %h exp %h", k, s_vec, e_vec); end
        end
        for (int c = 0; c < N; c++) begin
            chk++;
            if (hd[c] != tl[c]) begin err++; $display("FAIL random_drain ch%0d got %0d left exp 0", c, tl[c] - hd[c]); end
            chk++;
            if (frame_cnt[c] !== CW'(nfr[c])) begin err++; $display("FAIL random_cnt ch%0d got %0d exp %0d", c, frame_cnt[c], nfr[c] % (1 << CW)); end
        end
    endtask

    initial begin
        drive();
        test_reset();
        test_single();
        test_rr();
        test_stall();
        test_full();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
